// File: rtl/i3c_ccc_cmdq_master.sv
// CCC command queue for the I3C master: CPU-pushed command words are buffered in a FIFO,
// issued one at a time over valid/ready, and tracked to completion with sticky status and an IRQ.
module i3c_ccc_cmdq_master #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  CCC_ADDR  = 8'h01,
  parameter logic [7:0]  STAT_ADDR = 8'h02
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_cpu_wr_en,
  input  logic              i_cpu_rd_en,
  input  logic [7:0]        i_cpu_addr,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cmd_valid,
  output logic [DATA_W-1:0] o_cmd_data,
  input  logic              i_cmd_ready,
  input  logic              i_cmd_done,
  input  logic              i_cmd_err,
  output logic              o_busy,
  output logic              o_irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [2:0]        irq_en_q, irq_en_d;
  logic [DATA_W-1:0] last_wr_q, last_wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic              irq_q, irq_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ccc_wr, stat_wr, flush, push_req, push, pop, done_evt;
  logic              full, empty, busy;
  logic [2:0]        irq_en_wr;
  logic [18:0]       stat19;
  logic [DATA_W-1:0] stat_word;

  assign ccc_wr   = i_cpu_wr_en && (i_cpu_addr == CCC_ADDR);
  assign stat_wr  = i_cpu_wr_en && (i_cpu_addr == STAT_ADDR);
  assign flush    = ccc_wr && i_cpu_wdata[DATA_W-1];
  assign push_req = ccc_wr && !i_cpu_wdata[DATA_W-1];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // A full FIFO drops the word even when the head is popped in the same cycle.
  assign push     = push_req && !full;
  assign pop      = (state_q == ISSUE) && i_cmd_ready && !flush;
  assign done_evt = (state_q == WAIT) && i_cmd_done && !flush;
  assign busy     = (state_q != IDLE) || !empty;

  generate
    if (DATA_W >= 19) begin : g_irq_en_field
      assign irq_en_wr = i_cpu_wdata[18:16];
    end else begin : g_irq_en_none
      assign irq_en_wr = 3'b000;
    end
  endgenerate

  always_comb begin
    stat19        = '0;
    stat19[0]     = busy;
    stat19[1]     = full;
    stat19[2]     = empty;
    stat19[3]     = ovf_q;
    stat19[4]     = done_q;
    stat19[5]     = err_q;
    stat19[15:8]  = 8'(count_q);
    stat19[18:16] = irq_en_q;
  end

  assign stat_word = DATA_W'(stat19);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    done_d      = done_q;
    err_d       = err_q;
    irq_en_d    = irq_en_q;
    last_wr_d   = last_wr_q;
    rdata_d     = rdata_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    irq_d       = |({err_q, done_q, ovf_q} & irq_en_q);

    if (ccc_wr) begin
      last_wr_d = i_cpu_wdata;
    end
    if (stat_wr) begin
      irq_en_d = irq_en_wr;
    end
    // Reads return the register contents as they were before any same-cycle write.
    if (i_cpu_rd_en) begin
      if (i_cpu_addr == CCC_ADDR) begin
        rdata_d = last_wr_q;
      end else if (i_cpu_addr == STAT_ADDR) begin
        rdata_d = stat_word;
      end else begin
        rdata_d = '0;
      end
    end

    if (flush) begin
      state_d     = IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      ovf_d       = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      cmd_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      // Set events take precedence over the W1C clear.
      ovf_d  = (ovf_q  && !(stat_wr && i_cpu_wdata[3])) || (push_req && full);
      done_d = (done_q && !(stat_wr && i_cpu_wdata[4])) || done_evt;
      err_d  = (err_q  && !(stat_wr && i_cpu_wdata[5])) || (done_evt && i_cmd_err);

      case (state_q)
        IDLE: begin
          if (!empty) begin
            state_d     = ISSUE;
            cmd_valid_d = 1'b1;
            cmd_data_d  = mem_q[rd_ptr_q];
          end
        end
        ISSUE: begin
          if (i_cmd_ready) begin
            state_d     = WAIT;
            cmd_valid_d = 1'b0;
          end
        end
        WAIT: begin
          if (i_cmd_done) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d     = IDLE;
          cmd_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_cpu_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_en_q    <= 3'b000;
      last_wr_q   <= '0;
      rdata_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      err_q       <= err_d;
      irq_en_q    <= irq_en_d;
      last_wr_q   <= last_wr_d;
      rdata_q     <= rdata_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      irq_q       <= irq_d;
    end
  end

  assign o_cpu_rdata = rdata_q;
  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd_data  = cmd_data_q;
  assign o_busy      = busy;
  assign o_irq       = irq_q;

endmodule

// File: tb/tb_i3c_ccc_cmdq_master.sv
// Directed bench for i3c_ccc_cmdq_master: inputs change on the falling edge, outputs are
// checked on the falling edge against hand-computed values.
module tb_i3c_ccc_cmdq_master;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_cpu_wdata;
  logic        i_cpu_wr_en;
  logic        i_cpu_rd_en;
  logic [7:0]  i_cpu_addr;
  logic [31:0] o_cpu_rdata;
  logic        o_cmd_valid;
  logic [31:0] o_cmd_data;
  logic        i_cmd_ready;
  logic        i_cmd_done;
  logic        i_cmd_err;
  logic        o_busy;
  logic        o_irq;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  i3c_ccc_cmdq_master #(
    .DATA_W(32), .DEPTH(4), .CCC_ADDR(8'h01), .STAT_ADDR(8'h02)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cpu_wdata(i_cpu_wdata), .i_cpu_wr_en(i_cpu_wr_en), .i_cpu_rd_en(i_cpu_rd_en),
    .i_cpu_addr(i_cpu_addr), .o_cpu_rdata(o_cpu_rdata),
    .o_cmd_valid(o_cmd_valid), .o_cmd_data(o_cmd_data), .i_cmd_ready(i_cmd_ready),
    .i_cmd_done(i_cmd_done), .i_cmd_err(i_cmd_err),
    .o_busy(o_busy), .o_irq(o_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; the write is sampled on the following rising edge.
  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
    i_cpu_addr  = a;
    i_cpu_wdata = d;
    i_cpu_wr_en = 1'b1;
    @(negedge i_clk);
    i_cpu_wr_en = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d);
    i_cpu_addr  = a;
    i_cpu_rd_en = 1'b1;
    @(negedge i_clk);
    i_cpu_rd_en = 1'b0;
    d = o_cpu_rdata;
  endtask

  task automatic done_pulse(input logic err);
    i_cmd_done = 1'b1;
    i_cmd_err  = err;
    @(negedge i_clk);
    i_cmd_done = 1'b0;
    i_cmd_err  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    i_rst_n = 1'b0;
    i_cpu_wdata = '0; i_cpu_wr_en = 1'b0; i_cpu_rd_en = 1'b0; i_cpu_addr = '0;
    i_cmd_ready = 1'b0; i_cmd_done = 1'b0; i_cmd_err = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_valid", {31'b0, o_cmd_valid}, 32'd0);
    check("rst_busy",  {31'b0, o_busy},      32'd0);
    check("rst_irq",   {31'b0, o_irq},       32'd0);
    check("rst_rdata", o_cpu_rdata,          32'd0);
    check("rst_data",  o_cmd_data,           32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    cpu_rd(8'h02, rd);
    check("rst_stat", rd, 32'h0000_0004);

    // Single command
    cpu_wr(8'h01, 32'h0000_0001);
    check("single_valid_n1", {31'b0, o_cmd_valid}, 32'd0);
    check("single_busy_n1",  {31'b0, o_busy},      32'd1);
    @(negedge i_clk);
    check("single_valid_n2", {31'b0, o_cmd_valid}, 32'd1);
    check("single_data_n2",  o_cmd_data,           32'h0000_0001);
    i_cmd_ready = 1'b1;
    @(negedge i_clk);
    i_cmd_ready = 1'b0;
    check("single_wait_valid", {31'b0, o_cmd_valid}, 32'd0);
    check("single_wait_busy",  {31'b0, o_busy},      32'd1);
    done_pulse(1'b0);
    check("single_idle_busy", {31'b0, o_busy}, 32'd0);
    cpu_rd(8'h02, rd);
    check("single_stat", rd, 32'h0000_0014);
    cpu_wr(8'h02, 32'h0000_0010);
    cpu_rd(8'h02, rd);
    check("single_w1c_done", rd, 32'h0000_0004);

    // Fill and overflow with ready held low
    for (int k = 1; k <= 5; k++) cpu_wr(8'h01, 32'(k));
    check("fill_valid", {31'b0, o_cmd_valid}, 32'd1);
    check("fill_data",  o_cmd_data,           32'h0000_0001);
    cpu_rd(8'h02, rd);
    check("fill_stat", rd, 32'h0000_040B);
    cpu_rd(8'h01, rd);
    check("fill_last_wr", rd, 32'h0000_0005);
    for (int k = 1; k <= 4; k++) begin
      check("drain_valid", {31'b0, o_cmd_valid}, 32'd1);
      check("drain_order", o_cmd_data, 32'(k));
      i_cmd_ready = 1'b1;
      @(negedge i_clk);
      i_cmd_ready = 1'b0;
      check("drain_wait", {31'b0, o_cmd_valid}, 32'd0);
      done_pulse(1'b0);
      @(negedge i_clk);
    end
    check("drain_end_valid", {31'b0, o_cmd_valid}, 32'd0);
    check("drain_end_busy",  {31'b0, o_busy},      32'd0);
    cpu_wr(8'h02, 32'h0000_0018);
    cpu_rd(8'h02, rd);
    check("drain_w1c", rd, 32'h0000_0004);

    // Backpressure and ordering
    cpu_wr(8'h01, 32'h0000_000A);
    cpu_wr(8'h01, 32'h0000_000B);
    repeat (3) begin
      check("bp_hold_valid", {31'b0, o_cmd_valid}, 32'd1);
      check("bp_hold_data",  o_cmd_data,           32'h0000_000A);
      @(negedge i_clk);
    end
    i_cmd_ready = 1'b1;
    @(negedge i_clk);
    repeat (2) begin
      check("bp_one_outstanding", {31'b0, o_cmd_valid}, 32'd0);
      @(negedge i_clk);
    end
    check("bp_pre_done", {31'b0, o_cmd_valid}, 32'd0);
    done_pulse(1'b0);
    check("bp_idle", {31'b0, o_cmd_valid}, 32'd0);
    @(negedge i_clk);
    check("bp_second_valid", {31'b0, o_cmd_valid}, 32'd1);
    check("bp_second_data",  o_cmd_data,           32'h0000_000B);
    @(negedge i_clk);
    i_cmd_ready = 1'b0;
    check("bp_second_wait", {31'b0, o_cmd_valid}, 32'd0);
    done_pulse(1'b0);
    check("bp_end_busy", {31'b0, o_busy}, 32'd0);
    cpu_wr(8'h02, 32'h0000_0010);

    // Error path with ERR interrupt enabled
    cpu_wr(8'h02, 32'h0004_0000);
    cpu_wr(8'h01, 32'h0000_0033);
    @(negedge i_clk);
    i_cmd_ready = 1'b1;
    @(negedge i_clk);
    i_cmd_ready = 1'b0;
    done_pulse(1'b1);
    check("err_irq_m1", {31'b0, o_irq}, 32'd0);
    @(negedge i_clk);
    check("err_irq_m2", {31'b0, o_irq}, 32'd1);
    cpu_rd(8'h02, rd);
    check("err_stat", rd, 32'h0004_0034);
    cpu_wr(8'h02, 32'h0004_0020);
    @(negedge i_clk);
    check("err_irq_cleared", {31'b0, o_irq}, 32'd0);
    cpu_rd(8'h02, rd);
    check("err_w1c_stat", rd, 32'h0004_0014);
    cpu_wr(8'h02, 32'h0000_0000);

    // Flush while waiting on the first of three commands
    cpu_wr(8'h01, 32'h0000_0011);
    cpu_wr(8'h01, 32'h0000_0022);
    cpu_wr(8'h01, 32'h0000_0033);
    check("flush_issue_data", o_cmd_data, 32'h0000_0011);
    i_cmd_ready = 1'b1;
    @(negedge i_clk);
    i_cmd_ready = 1'b0;
    check("flush_pre_busy", {31'b0, o_busy}, 32'd1);
    cpu_wr(8'h01, 32'h8000_0000);
    check("flush_busy",  {31'b0, o_busy},      32'd0);
    check("flush_valid", {31'b0, o_cmd_valid}, 32'd0);
    cpu_rd(8'h02, rd);
    check("flush_stat", rd, 32'h0000_0004);
    done_pulse(1'b0);
    cpu_rd(8'h02, rd);
    check("flush_late_done", rd, 32'h0000_0004);

    // Asynchronous reset while a command is being offered
    cpu_wr(8'h02, 32'h0001_0000);
    for (int k = 1; k <= 5; k++) cpu_wr(8'h01, 32'(k));
    cpu_rd(8'h01, rd);
    check("prereset_rdata", rd, 32'h0000_0005);
    check("prereset_irq",   {31'b0, o_irq},       32'd1);
    check("prereset_valid", {31'b0, o_cmd_valid}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, o_cmd_valid}, 32'd0);
    check("arst_busy",  {31'b0, o_busy},      32'd0);
    check("arst_irq",   {31'b0, o_irq},       32'd0);
    check("arst_rdata", o_cpu_rdata,          32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    cpu_rd(8'h01, rd);
    check("arst_last_wr", rd, 32'd0);
    cpu_rd(8'h02, rd);
    check("arst_stat", rd, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
